// File: rtl/univ_mod_counter_pkg.sv
// Shared types for the universal modulo counter: the per-edge update
// operation and the helper that resolves input priority into one operation.
package univ_mod_counter_pkg;

    // One update is chosen per rising edge; HOLD keeps the count unchanged.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_CLEAR = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STEP  = 2'd3
    } op_e;

    // Resolve the request lines into one operation: clear beats load,
    // load beats a count step, and with nothing requested the count holds.
    function automatic op_e select_op(
        input logic syn_clr,
        input logic load,
        input logic step
    );
        op_e op;
        if (syn_clr) begin
            op = OP_CLEAR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (step) begin
            op = OP_STEP;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/univ_mod_counter_mod_m_tick.sv
// Clock-enable prescaler: counts 0..M-1 while en is high, holds while en
// is low, and raises tick during the cycle it sits on M-1 with en high.
// With M=1 the counter never leaves 0, so tick simply follows en.
module mod_m_tick #(
    parameter int M = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A one-state prescaler still needs a one-bit register.
    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    // Next prescaler state: clear wins, otherwise advance and roll over at M-1.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            if (cnt_reg == LAST) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + W'(1);
            end
        end
    end

    // Prescaler register, cleared immediately by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/univ_mod_counter.sv
// Universal modulo counter: counts 0..m up or down with wrap or saturate
// at the boundaries, parallel load clipped to m, synchronous clear, a
// prescaled count enable, a one-cycle wrap pulse and a sticky overflow.
module univ_mod_counter
    import univ_mod_counter_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic         sat,
    input  logic [N-1:0] d,
    input  logic [N-1:0] m,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap,
    output logic         ovf,
    output logic         tick
);

    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;
    logic         wrap_reg;
    logic         wrap_next;
    logic         ovf_reg;
    logic         ovf_next;
    logic         step;
    op_e          op;

    // The prescaler is cleared together with the count so a clear always
    // restarts a full prescale interval; load leaves it running.
    mod_m_tick #(
        .M (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (syn_clr),
        .en    (en),
        .tick  (tick)
    );

    assign step = en & tick;
    assign op   = select_op(syn_clr, load, step);

    // Next count and flags. wrap defaults low so it only lasts the one
    // cycle in which the post-wrap count is visible.
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        ovf_next  = ovf_reg;
        unique case (op)
            OP_CLEAR: begin
                q_next   = '0;
                ovf_next = 1'b0;
            end
            OP_LOAD: begin
                // Loads above the top value are clipped to m.
                q_next = (d > m) ? m : d;
            end
            OP_STEP: begin
                if (q_reg > m) begin
                    // m was lowered below the count: pull back to the top
                    // silently, this is not a boundary event.
                    q_next = m;
                end else if (up) begin
                    if (q_reg == m) begin
                        ovf_next = 1'b1;
                        if (sat) begin
                            q_next = m;
                        end else begin
                            q_next    = '0;
                            wrap_next = 1'b1;
                        end
                    end else begin
                        q_next = q_reg + N'(1);
                    end
                end else begin
                    if (q_reg == '0) begin
                        ovf_next = 1'b1;
                        if (sat) begin
                            q_next = '0;
                        end else begin
                            q_next    = m;
                            wrap_next = 1'b1;
                        end
                    end else begin
                        q_next = q_reg - N'(1);
                    end
                end
            end
            default: begin
                q_next = q_reg;
            end
        endcase
    end

    // Count and flag registers, cleared immediately by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign q        = q_reg;
    assign wrap     = wrap_reg;
    assign ovf      = ovf_reg;
    assign max_tick = (q_reg == m);
    assign min_tick = (q_reg == '0);

endmodule

// File: tb/tb_univ_mod_counter.sv
// Bench for univ_mod_counter: two instances (PRESCALE=1 and PRESCALE=4)
// share stimulus; an arithmetic model of the counting rules is compared on
// every falling edge, and directed steps pin literal expected values.
module tb_univ_mod_counter;

    localparam int PS0 = 1;
    localparam int PS1 = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       syn_clr = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       sat = 1'b0;
    logic [3:0] d = 4'd0;
    logic [3:0] m = 4'd9;

    logic [3:0] q0, q1;
    logic       max0, max1, min0, min1, wrap0, wrap1, ovf0, ovf1, tick0, tick1;

    int checks = 0;
    int failures = 0;

    // behavioural model state: count, prescale position, wrap pulse, overflow
    int mq [2];
    int mp [2];
    int mw [2];
    int mo [2];
    int ps [2];

    always #5 clk = ~clk;

    univ_mod_counter #(.N(4), .PRESCALE(PS0)) u0 (
        .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en),
        .up(up), .sat(sat), .d(d), .m(m), .q(q0), .max_tick(max0),
        .min_tick(min0), .wrap(wrap0), .ovf(ovf0), .tick(tick0)
    );

    univ_mod_counter #(.N(4), .PRESCALE(PS1)) u1 (
        .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en),
        .up(up), .sat(sat), .d(d), .m(m), .q(q1), .max_tick(max1),
        .min_tick(min1), .wrap(wrap1), .ovf(ovf1), .tick(tick1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: apply the counting rules with plain integer arithmetic.
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            automatic int top = int'(m);
            automatic int q = mq[i];
            automatic int p = mp[i];
            automatic int w = 0;
            automatic int o = mo[i];
            automatic bit stepping = en && (mp[i] == ps[i] - 1);
            if (!reset) begin
                q = 0; p = 0; o = 0;
            end else if (syn_clr) begin
                q = 0; p = 0; o = 0;
            end else begin
                if (en) p = (p + 1) % ps[i];
                if (load) begin
                    q = (int'(d) > top) ? top : int'(d);
                end else if (stepping) begin
                    if (q > top) q = top;
                    else if (up && q == top) begin
                        o = 1;
                        if (!sat) begin q = 0; w = 1; end
                    end else if (up) q = q + 1;
                    else if (q == 0) begin
                        o = 1;
                        if (!sat) begin q = top; w = 1; end
                    end else q = q - 1;
                end
            end
            mq[i] <= q;
            mp[i] <= p;
            mw[i] <= w;
            mo[i] <= o;
        end
    end

    // Compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin
        chk("u0.q", int'(q0), mq[0]);
        chk("u0.max_tick", int'(max0), int'(mq[0] == int'(m)));
        chk("u0.min_tick", int'(min0), int'(mq[0] == 0));
        chk("u0.wrap", int'(wrap0), mw[0]);
        chk("u0.ovf", int'(ovf0), mo[0]);
        chk("u0.tick", int'(tick0), int'(en && mp[0] == PS0 - 1));
        chk("u1.q", int'(q1), mq[1]);
        chk("u1.max_tick", int'(max1), int'(mq[1] == int'(m)));
        chk("u1.min_tick", int'(min1), int'(mq[1] == 0));
        chk("u1.wrap", int'(wrap1), mw[1]);
        chk("u1.ovf", int'(ovf1), mo[1]);
        chk("u1.tick", int'(tick1), int'(en && mp[1] == PS1 - 1));
    end

    // Advance one edge; inputs change 2 time units after it.
    task automatic cyc();
        @(posedge clk);
        #2;
        $display("txn t=%0t clr=%0b ld=%0b en=%0b up=%0b sat=%0b d=%0d m=%0d q0=%0d q1=%0d wrap0=%0b ovf0=%0b",
                 $time, syn_clr, load, en, up, sat, d, m, q0, q1, wrap0, ovf0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ps[0] = PS0;
        ps[1] = PS1;
        #1 reset = 1'b0;
        #2;
        chk("rst.q", int'(q0), 0);
        chk("rst.min_tick", int'(min0), 1);
        chk("rst.max_tick_m9", int'(max0), 0);
        chk("rst.ovf", int'(ovf0), 0);
        m = 4'd0;
        #1 chk("rst.max_tick_m0", int'(max0), 1);
        m = 4'd9;
        cyc();
        reset = 1'b1;

        // load with clipping
        load = 1'b1; d = 4'd3; cyc();
        chk("load.q3", int'(q0), 3);
        d = 4'd12; cyc();
        chk("load.clip_q", int'(q0), 9);
        chk("load.ovf", int'(ovf0), 0);

        // up wrap
        d = 4'd7; cyc();
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        cyc(); chk("upw.q8", int'(q0), 8); chk("upw.max8", int'(max0), 0);
        cyc(); chk("upw.q9", int'(q0), 9); chk("upw.max9", int'(max0), 1);
        chk("upw.wrap9", int'(wrap0), 0);
        cyc(); chk("upw.q0", int'(q0), 0); chk("upw.wrap0", int'(wrap0), 1);
        chk("upw.ovf0", int'(ovf0), 1); chk("upw.max0", int'(max0), 0);
        cyc(); chk("upw.q1", int'(q0), 1); chk("upw.wrap1", int'(wrap0), 0);
        chk("upw.ovf1", int'(ovf0), 1);

        // down saturate
        en = 1'b0; syn_clr = 1'b1; cyc();
        syn_clr = 1'b0; load = 1'b1; d = 4'd2; cyc();
        load = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b1;
        cyc(); chk("dns.q1", int'(q0), 1); chk("dns.min1", int'(min0), 0);
        cyc(); chk("dns.q0", int'(q0), 0); chk("dns.min0", int'(min0), 1);
        chk("dns.ovf_before_clip", int'(ovf0), 0);
        cyc(); chk("dns.q0b", int'(q0), 0); chk("dns.ovf", int'(ovf0), 1);
        chk("dns.wrap", int'(wrap0), 0);
        cyc(); chk("dns.q0c", int'(q0), 0);

        // down wrap from 0 to m
        sat = 1'b0; cyc();
        chk("dnw.q9", int'(q0), 9); chk("dnw.wrap", int'(wrap0), 1);

        // m=0 boundary: step keeps q=0 with a wrap pulse
        en = 1'b0; syn_clr = 1'b1; cyc();
        syn_clr = 1'b0; m = 4'd0; en = 1'b1; up = 1'b1; cyc();
        chk("m0.q", int'(q0), 0); chk("m0.wrap", int'(wrap0), 1);
        chk("m0.ovf", int'(ovf0), 1);
        m = 4'd9;

        // priority and lowered m
        en = 1'b0; load = 1'b1; d = 4'd5; cyc();
        chk("pri.q5", int'(q0), 5);
        syn_clr = 1'b1; en = 1'b1; d = 4'd7; cyc();
        chk("pri.q0", int'(q0), 0); chk("pri.ovf", int'(ovf0), 0);
        syn_clr = 1'b0; en = 1'b0; d = 4'd8; cyc();
        load = 1'b0; m = 4'd3;
        #1 chk("low.max", int'(max0), 0);
        en = 1'b1; up = 1'b1; cyc();
        chk("low.q3", int'(q0), 3); chk("low.wrap", int'(wrap0), 0);
        chk("low.ovf", int'(ovf0), 0);
        m = 4'd9;

        // prescale on u1
        en = 1'b0; syn_clr = 1'b1; cyc();
        syn_clr = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("ps.q", int'(q1), k / 4);
            chk("ps.tick", int'(tick1), int'(k % 4 == 3));
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("ps.hold_q", int'(q1), 2);
            chk("ps.hold_tick", int'(tick1), 0);
        end
        en = 1'b1;
        cyc(); cyc(); cyc();
        chk("ps.q_before", int'(q1), 2); chk("ps.tick_last", int'(tick1), 1);
        cyc();
        chk("ps.q3", int'(q1), 3);

        // asynchronous reset mid-cycle
        en = 1'b0; load = 1'b1; d = 4'd6; cyc();
        load = 1'b0;
        chk("ar.q6", int'(q0), 6); chk("ar.ovf_pre", int'(ovf0), 1);
        #1 reset = 1'b0;
        #1;
        chk("ar.q", int'(q0), 0); chk("ar.ovf", int'(ovf0), 0);
        chk("ar.q1", int'(q1), 3 * 0);
        cyc();
        reset = 1'b1; en = 1'b1; up = 1'b1;
        cyc();
        chk("ar.resume", int'(q0), 1);
        cyc();
        chk("ar.resume2", int'(q0), 2);
        en = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
